// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// slave = the unit itself, master = execute stage plus memory side.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_WE;
  logic [DATA_WIDTH-1:0] mem_dIn;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_WE, mem_dIn
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_WE, mem_dIn
  );
endinterface

// File: rtl/load_store_unit.sv
// RV64 load/store onto a 64-bit memory port; sub-doubleword stores by read-modify-write.
// 2 cycles for loads/SD, 3 for sub-word stores, 1 for errors; one request in flight, req_ready only in IDLE.
module load_store_unit #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave lsu
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_e;

  typedef struct packed {
    logic                  store;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_e                state_q, state_d;
  req_t                  req_q, req_d;
  logic [DATA_WIDTH-1:0] rdword_q, rdword_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  misaligned;
  logic                  illegal;
  logic                  bad_req;
  logic [5:0]            lane_shift;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] merged;

  assign accept     = lsu.req_valid && (state_q == IDLE);
  assign lane_shift = {req_q.addr[2:0], 3'b000};
  assign lane_data  = lsu.mem_dout >> lane_shift;

  always_comb begin
    misaligned = 1'b0;
    case (lsu.req_funct3[1:0])
      2'b01:   misaligned = lsu.req_addr[0];
      2'b10:   misaligned = |lsu.req_addr[1:0];
      2'b11:   misaligned = |lsu.req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
    illegal = (lsu.req_funct3 == 3'b111) || (lsu.req_store && lsu.req_funct3[2]);
    bad_req = misaligned || illegal;
  end

  // Load extension and store byte-lane merge both work on the lane shifted to bit 0.
  always_comb begin
    load_ext = lane_data;
    case (req_q.funct3)
      3'b000:  load_ext = {{(DATA_WIDTH-8){lane_data[7]}},   lane_data[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){lane_data[15]}}, lane_data[15:0]};
      3'b010:  load_ext = {{(DATA_WIDTH-32){lane_data[31]}}, lane_data[31:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}},  lane_data[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane_data[15:0]};
      3'b110:  load_ext = {{(DATA_WIDTH-32){1'b0}}, lane_data[31:0]};
      default: load_ext = lane_data;
    endcase

    byte_mask = '1;
    case (req_q.funct3[1:0])
      2'b00:   byte_mask = {{(DATA_WIDTH-8){1'b0}},  8'hFF};
      2'b01:   byte_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
      2'b10:   byte_mask = {{(DATA_WIDTH-32){1'b0}}, 32'hFFFF_FFFF};
      default: byte_mask = '1;
    endcase
    byte_mask = byte_mask << lane_shift;
    merged    = (rdword_q & ~byte_mask) | ((req_q.wdata << lane_shift) & byte_mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      rdword_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      rdword_q <= rdword_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bad_req)                      state_d = RESP;
          else if (!lsu.req_store)          state_d = LOAD;
          else if (lsu.req_funct3 == 3'b011) state_d = WRITE;
          else                              state_d = RMW_RD;
        end
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response fields change only on the edge that enters RESP, so they hold between responses.
  always_comb begin
    req_d    = req_q;
    rdword_d = rdword_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d.store  = lsu.req_store;
          req_d.funct3 = lsu.req_funct3;
          req_d.addr   = lsu.req_addr;
          req_d.wdata  = lsu.req_wdata;
          if (bad_req) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      LOAD: begin
        rdata_d = load_ext;
        err_d   = 1'b0;
      end
      RMW_RD: rdword_d = lsu.mem_dout;
      WRITE: begin
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    lsu.req_ready   = (state_q == IDLE);
    lsu.resp_valid  = (state_q == RESP);
    lsu.resp_rdata  = rdata_q;
    lsu.resp_err    = err_q;
    lsu.mem_address = {req_q.addr[ADDR_WIDTH-1:3], 3'b000};
    lsu.mem_WE      = (state_q == WRITE);
    lsu.mem_dIn     = '0;
    if (state_q == WRITE) begin
      lsu.mem_dIn = (req_q.funct3[1:0] == 2'b11) ? req_q.wdata : merged;
    end
  end
endmodule
